// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
//   state_t : scheduler FSM state (IDLE, WAIT, RESP)
//   N_W/D_W : dividend / divisor widths
//   Q_W     : quotient / remainder width
//   SAT_Q   : quotient reported for screened (dbz / overflow) requests
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int Q_W = 8;

    localparam logic [Q_W-1:0] SAT_Q = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index searched first; search proceeds upward with wrap
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted requester
//   any     : at least one request present
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/div_array_sched.sv
// Shares one 16/8 array divider between NREQ requesters.
//   req_*  : per-requester valid/ready request channel (operands packed per slice)
//   div_*  : registered operands + instance select to the external divider, q/r back
//   rsp_*  : valid/ready response channel with requester id, q, r and screen flags
// Operands are held for DIV_LAT cycles so the divider can settle as a multicycle
// path; divide-by-zero and quotient overflow are answered without the divider.
module div_array_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DIV_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_n,
    input  logic [8*NREQ-1:0] req_d,
    input  logic [NREQ-1:0]   req_approx,
    output logic [N_W-1:0]    div_n,
    output logic [D_W-1:0]    div_d,
    output logic              div_sel_approx,
    input  logic [Q_W-1:0]    div_q,
    input  logic [Q_W-1:0]    div_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [Q_W-1:0]    rsp_q,
    output logic [Q_W-1:0]    rsp_r,
    output logic              rsp_dbz,
    output logic              rsp_ovf
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0]   div_n_q, div_n_d;
    logic [D_W-1:0]   div_d_q, div_d_d;
    logic             sel_ap_q, sel_ap_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [Q_W-1:0]   q_q, q_d, r_q, r_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d, vld_q, vld_d;

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [N_W-1:0]   pick_n;
    logic [D_W-1:0]   pick_d;
    logic             pick_ap;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Only IDLE accepts; gated by rst so every output reads 0 during reset.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    always_comb begin
        pick_n  = '0;
        pick_d  = '0;
        pick_ap = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                pick_n  = req_n[16*i +: 16];
                pick_d  = req_d[8*i +: 8];
                pick_ap = req_approx[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        div_n_d  = div_n_q;
        div_d_d  = div_d_q;
        sel_ap_d = sel_ap_q;
        id_d     = id_q;
        q_d      = q_q;
        r_d      = r_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        vld_d    = vld_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    div_n_d  = pick_n;
                    div_d_d  = pick_d;
                    sel_ap_d = pick_ap;
                    id_d     = gnt_idx;
                    rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % NREQ);
                    if (pick_d == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = SAT_Q;
                        r_d     = pick_n[Q_W-1:0];
                        vld_d   = 1'b1;
                        state_d = RESP;
                    end else if (pick_n[N_W-1:D_W] >= pick_d) begin
                        // Quotient would not fit in Q_W bits; the array result is meaningless.
                        ovf_d   = 1'b1;
                        q_d     = SAT_Q;
                        r_d     = pick_n[Q_W-1:0];
                        vld_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(DIV_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            div_n_q  <= '0;
            div_d_q  <= '0;
            sel_ap_q <= 1'b0;
            id_q     <= '0;
            q_q      <= '0;
            r_q      <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            div_n_q  <= div_n_d;
            div_d_q  <= div_d_d;
            sel_ap_q <= sel_ap_d;
            id_q     <= id_d;
            q_q      <= q_d;
            r_q      <= r_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
        end
    end

    assign div_n          = div_n_q;
    assign div_d          = div_d_q;
    assign div_sel_approx = sel_ap_q;
    assign rsp_valid      = vld_q;
    assign rsp_id         = id_q;
    assign rsp_q          = q_q;
    assign rsp_r          = r_q;
    assign rsp_dbz        = dbz_q;
    assign rsp_ovf        = ovf_q;

endmodule

// File: tb/tb_div_array_sched.sv
// Bench for div_array_sched: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the scheduler.
module tb_div_array_sched;

    localparam int NREQ    = 2;
    localparam int DIV_LAT = 2;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [16*NREQ-1:0]    req_n;
    logic [8*NREQ-1:0]     req_d;
    logic [NREQ-1:0]       req_approx;
    logic [15:0]           div_n;
    logic [7:0]            div_d;
    logic                  div_sel_approx;
    logic [7:0]            div_q;
    logic [7:0]            div_r;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [7:0]            rsp_q;
    logic [7:0]            rsp_r;
    logic                  rsp_dbz;
    logic                  rsp_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    div_array_sched #(.NREQ(NREQ), .DIV_LAT(DIV_LAT), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_n          (req_n),
        .req_d          (req_d),
        .req_approx     (req_approx),
        .div_n          (div_n),
        .div_d          (div_d),
        .div_sel_approx (div_sel_approx),
        .div_q          (div_q),
        .div_r          (div_r),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_q          (rsp_q),
        .rsp_r          (rsp_r),
        .rsp_dbz        (rsp_dbz),
        .rsp_ovf        (rsp_ovf)
    );

    // Divider stub: exact divide, or a fixed pattern from the "approximate" instance.
    always_comb begin
        div_q = 8'h00;
        div_r = 8'h00;
        if (div_sel_approx) begin
            div_q = 8'h0D;
            div_r = 8'h09;
        end else if (div_d != 8'h00) begin
            div_q = 8'(div_n / {8'h00, div_d});
            div_r = 8'(div_n % {8'h00, div_d});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_busy, m_rv;
    int          m_ptr, m_wait;
    logic [15:0] e_n;
    logic [7:0]  e_d, e_q, e_r;
    bit          e_ap, e_dbz, e_ovf;
    int          e_id;

    initial begin
        m_busy = 0; m_rv = 0; m_ptr = 0; m_wait = 0;
        e_n = '0; e_d = '0; e_q = '0; e_r = '0; e_ap = 0; e_dbz = 0; e_ovf = 0; e_id = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_rv = 0; m_ptr = 0; m_wait = 0;
                e_dbz = 0; e_ovf = 0;
            end else if (!m_busy) begin
                int g;
                g = rr_pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_busy = 1;
                    e_n  = req_n[16*g +: 16];
                    e_d  = req_d[8*g +: 8];
                    e_ap = req_approx[g];
                    e_id = g;
                    m_ptr = (g + 1) % NREQ;
                    if (e_d == 0) begin
                        e_dbz = 1; e_q = 8'hFF; e_r = e_n[7:0]; m_rv = 1;
                    end else if (e_n[15:8] >= e_d) begin
                        e_ovf = 1; e_q = 8'hFF; e_r = e_n[7:0]; m_rv = 1;
                    end else begin
                        m_wait = DIV_LAT;
                        if (e_ap) begin
                            e_q = 8'h0D; e_r = 8'h09;
                        end else begin
                            e_q = 8'(e_n / e_d); e_r = 8'(e_n % e_d);
                        end
                    end
                end
            end else if (m_rv) begin
                if (rsp_ready) begin
                    m_busy = 0; m_rv = 0; e_dbz = 0; e_ovf = 0;
                end
            end else begin
                m_wait--;
                if (m_wait == 0) m_rv = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_div", {div_n, div_d, div_sel_approx}, 0);
                chk("rst_rsp", {rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_ovf}, 0);
            end else begin
                int g;
                logic [NREQ-1:0] er;
                g  = m_busy ? -1 : rr_pick(req_valid, m_ptr);
                er = (g >= 0) ? NREQ'(1 << g) : '0;
                chk("req_ready", req_ready, er);
                chk("ready_onehot0", ($countones(req_ready) <= 1), 1);
                chk("rsp_valid", rsp_valid, m_rv);
                chk("rsp_dbz", rsp_dbz, e_dbz);
                chk("rsp_ovf", rsp_ovf, e_ovf);
                if (m_rv) begin
                    chk("rsp_id", rsp_id, e_id);
                    chk("rsp_q", rsp_q, e_q);
                    chk("rsp_r", rsp_r, e_r);
                end
                if (m_busy) begin
                    chk("div_n", div_n, e_n);
                    chk("div_d", div_d, e_d);
                    chk("div_sel", div_sel_approx, e_ap);
                end
                if (rsp_valid && rsp_ready) hs_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] n, input logic [7:0] d, input bit ap);
        req_n[16*i +: 16] = n;
        req_d[8*i +: 8]   = d;
        req_approx[i]     = ap;
        req_valid[i]      = 1'b1;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (DIV_LAT + 4) cyc();
    endtask

    // Issue one request, wait for the accept, then count cycles until rsp_valid.
    task automatic do_op(input int i, input logic [15:0] n, input logic [7:0] d, input bit ap,
                         output int lat);
        bit acc;
        int k;
        acc = 0;
        k = 0;
        set_req(i, n, d, ap);
        while (!acc && k < 20) begin
            @(negedge clk);
            acc = req_ready[i];
            cyc();
            k++;
        end
        clr_req(i);
        if (!acc) chk("accept_timeout", 0, 1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    initial begin
        int lat, ng, h0;
        int gs[4];
        logic [NREQ-1:0] acc;
        rst = 1'b1;
        req_valid = '0; req_n = '0; req_d = '0; req_approx = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // basic exact divide: 100 / 7 = 14 r 2
        do_op(0, 16'h0064, 8'h07, 1'b0, lat);
        chk("basic_lat", lat, 3);
        chk("basic_id", rsp_id, 0);
        chk("basic_q", rsp_q, 8'h0E);
        chk("basic_r", rsp_r, 8'h02);
        chk("basic_flags", {rsp_dbz, rsp_ovf}, 0);
        chk("basic_div_n", div_n, 16'h0064);
        cyc();

        // divide by zero on requester 1
        do_op(1, 16'h1234, 8'h00, 1'b0, lat);
        chk("dbz_lat", lat, 1);
        chk("dbz_flag", rsp_dbz, 1);
        chk("dbz_q", rsp_q, 8'hFF);
        chk("dbz_r", rsp_r, 8'h34);
        chk("dbz_id", rsp_id, 1);
        cyc();

        // round robin with both requesters continuously valid
        set_req(0, 16'h0010, 8'h03, 1'b0);
        set_req(1, 16'h0020, 8'h05, 1'b0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gs[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
            cyc();
        end
        clr_req(0);
        clr_req(1);
        chk("rr_count", ng, 4);
        chk("rr_g0", gs[0], 0);
        chk("rr_g1", gs[1], 1);
        chk("rr_g2", gs[2], 0);
        chk("rr_g3", gs[3], 1);
        drain();

        // quotient overflow: 0x08 >= 0x08
        do_op(0, 16'h0800, 8'h08, 1'b0, lat);
        chk("ovf_lat", lat, 1);
        chk("ovf_flag", {rsp_ovf, rsp_dbz}, 2'b10);
        chk("ovf_q", rsp_q, 8'hFF);
        chk("ovf_r", rsp_r, 8'h00);
        cyc();

        // backpressure: 0x0100 / 0x10 = 0x10 r 0, held for 5 cycles
        rsp_ready = 1'b0;
        do_op(1, 16'h0100, 8'h10, 1'b0, lat);
        chk("bp_lat", lat, 3);
        set_req(0, 16'h0030, 8'h04, 1'b0);
        h0 = hs_cnt;
        repeat (5) begin
            cyc();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_rsp", {rsp_id, rsp_q, rsp_r}, {2'd1, 8'h10, 8'h00});
            chk("bp_div", {div_n, div_d}, {16'h0100, 8'h10});
        end
        rsp_ready = 1'b1;
        cyc();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", req_ready, 2'b01);
        cyc();
        clr_req(0);
        chk("bp_one_handshake", hs_cnt - h0, 1);
        chk("bp_next_accept", div_n, 16'h0030);
        drain();

        // approximate instance select
        rsp_ready = 1'b0;
        do_op(0, 16'h0064, 8'h07, 1'b1, lat);
        chk("ap_lat", lat, 3);
        chk("ap_sel", div_sel_approx, 1);
        chk("ap_q", rsp_q, 8'h0D);
        chk("ap_r", rsp_r, 8'h09);
        drain();

        // reset during WAIT
        set_req(0, 16'h0200, 8'h09, 1'b0);
        @(negedge clk);
        chk("rstw_accept", req_ready, 2'b01);
        cyc();
        clr_req(0);
        rst = 1'b1;
        set_req(0, 16'h0011, 8'h02, 1'b0);
        set_req(1, 16'h0022, 8'h03, 1'b0);
        @(negedge clk);
        chk("rstw_valid", rsp_valid, 0);
        chk("rstw_div_n", div_n, 0);
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_first_grant", req_ready, 2'b01);
        cyc();
        clr_req(0);
        clr_req(1);
        drain();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    logic [15:0] n;
                    logic [7:0]  d;
                    d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                    n = 16'($urandom);
                    if (d != 0 && $urandom_range(0, 3) != 0) n[15:8] = 8'($urandom % d);
                    set_req(i, n, d, $urandom_range(0, 3) == 0);
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (c == 250) rst = 1'b1;
            if (c == 252) rst = 1'b0;
        end
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_array_sched.md
Name: div_array_sched

Overview:
- Sequences and shares one 16/8 combinational array divider datapath (an exact instance and an approximate-row instance, selected by a mux outside this block) between NREQ requesters.
- Arbitrates round-robin, registers operands, and holds them stable for a DIV_LAT-cycle multicycle settle window.
- Screens divide-by-zero and quotient overflow before issue.
- Returns q/r with the requester id over a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DIV_LAT, 2, cycles the divider operands are held before q/r is captured (>=1).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NREQ.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_n  in  16*NREQ  dividends; slice i = bits [16i+15:16i].
- req_d  in  8*NREQ  divisors; slice i = bits [8i+7:8i].
- req_approx  in  NREQ  1 = use approximate divider instance for this request.
- div_n  out  16  dividend to divider datapath.
- div_d  out  8  divisor to divider datapath.
- div_sel_approx  out  1  instance select for the external q/r mux.
- div_q  in  8  quotient from the selected instance.
- div_r  in  8  remainder from the selected instance.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester served.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_dbz  out  1  divisor was zero.
- rsp_ovf  out  1  n[15:8] >= d with d != 0; quotient does not fit in 8 bits.

Behaviour:
- Reset values: all outputs 0. State is IDLE, rr_ptr is 0, wait counter is 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i] set, searching upward from rr_ptr with wrap.
  - req_ready[grant] = 1, combinational from req_valid and state. All req_ready bits are 0 outside IDLE.
- Accept on req_valid[i] & req_ready[i] in cycle T:
  - Latch n, d, approx and id into div_n, div_d, div_sel_approx and rsp_id.
  - rr_ptr <= (i+1) mod NREQ.
- Screening at accept:
  - d == 0: go to RESP with rsp_dbz=1, rsp_q=8'hFF, rsp_r=n[7:0].
  - n[15:8] >= d: go to RESP with rsp_ovf=1, rsp_q=8'hFF, rsp_r=n[7:0].
  - Both screened paths assert rsp_valid in cycle T+1; the divider result is not used.
- Normal path: go to WAIT and load the counter with DIV_LAT-1.
- WAIT:
  - div_n, div_d and div_sel_approx are held constant.
  - The counter decrements each cycle. When it reaches 0, capture div_q/div_r into rsp_q/rsp_r and go to RESP.
  - rsp_valid rises in cycle T+DIV_LAT+1.
- RESP:
  - rsp_valid=1. All rsp_* outputs and div_* outputs are stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, flags cleared, next state IDLE.
  - The earliest next accept is the cycle after the response handshake. Throughput is one op per DIV_LAT+2 cycles.
- No combinational path from rsp_ready to req_ready.
- Requests not granted in a cycle are not consumed; requesters hold req_valid and operands until accepted.
- The divider output is treated as correct only when n[15:8] < d; the screening above enforces this.
- In approx mode the captured value is whatever the approximate instance produces. No correction is applied.
- rst asserted in any state: return to reset values immediately (asynchronous).
  - Any in-flight operation is dropped with no response.
  - rr_ptr returns to 0.

Decomposition:
- Shared package div_sched_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Constants N_W=16, D_W=8, Q_W=8, and SAT_Q=8'hFF.
- One natural sub-module: rr_arbiter (NREQ-bit request vector plus pointer in, one-hot grant plus index out; purely combinational).

Test Plan:
- Basic exact divide: req0 n=16'h0064, d=8'h07, approx=0, divider stub = exact model.
  - Required: rsp_valid at T+3 (DIV_LAT=2), rsp_id=0, q=8'h0E, r=8'h02, flags=0.
  - Required: div_n/div_d stable throughout WAIT.
- Screening:
  - req1 d=8'h00, n=16'h1234 → T+1 rsp_dbz=1, q=8'hFF, r=8'h34, rsp_id=1.
  - n=16'h0800, d=8'h08 → rsp_ovf=1, q=8'hFF, r=8'h00.
- Round-robin: both requesters valid continuously, rsp_ready=1.
  - Required: grant sequence 0,1,0,1 and never two req_ready bits high.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_* and div_* unchanged and req_ready=0 for all 5 cycles.
  - Required: release gives exactly one handshake, then a new accept the next cycle.
- Approx select: req0 approx=1 with a stub returning q=8'h0D, r=8'h09 when div_sel_approx=1.
  - Required: div_sel_approx=1 throughout WAIT/RESP and the response carries 8'h0D/8'h09.
- Reset mid-operation: assert rst during WAIT.
  - Required: rsp_valid=0 and all outputs 0 while rst is high.
  - Required: after release, rr_ptr=0, so with both requesters valid req0 is granted first.
